// File: rtl/if_stage_if.sv
// Instruction-memory fetch bus between the IF stage (master) and instruction memory (slave).
// The master holds imem_addr stable while imem_req is high until imem_ack arrives.
interface if_stage_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );
endinterface

// File: rtl/if_stage.sv
// MIPS instruction-fetch stage: PC register, req/ack fetch FSM, IF/ID pipeline register,
// and the PC+4 / branch-target adders that feed the external next-PC mux.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                clk,
  input  logic                rst,
  if_stage_if.master          imem,
  input  logic         [31:0] next_pc,
  input  logic         [31:0] branch_imm,
  input  logic                stall,
  input  logic                flush,
  output logic         [31:0] pc,
  output logic         [31:0] pc_plus4,
  output logic         [31:0] branch_target,
  output logic         [31:0] id_instr,
  output logic         [31:0] id_pc_plus4,
  output logic                id_valid
);

  localparam logic [1:0] S_RESET   = 2'd0;
  localparam logic [1:0] S_FETCH   = 2'd1;
  localparam logic [1:0] S_HELD    = 2'd2;
  localparam logic [1:0] S_DISCARD = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] id_instr_q, id_instr_d;
  logic [31:0] id_pc_plus4_q, id_pc_plus4_d;
  logic        id_valid_q, id_valid_d;
  logic [31:0] hold_buf_q, hold_buf_d;
  logic [31:0] redirect_pc_q, redirect_pc_d;

  // Both adders wrap modulo 2^32; the shift drops branch_imm[31:30].
  assign pc_plus4      = pc_q + 32'd4;
  assign branch_target = id_pc_plus4_q + (branch_imm << 2);

  assign pc          = pc_q;
  assign id_instr    = id_instr_q;
  assign id_pc_plus4 = id_pc_plus4_q;
  assign id_valid    = id_valid_q;

  assign imem.imem_addr = pc_q;
  assign imem.imem_req  = (state_q == S_FETCH) || (state_q == S_DISCARD);

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    id_instr_d    = id_instr_q;
    id_pc_plus4_d = id_pc_plus4_q;
    id_valid_d    = id_valid_q;
    hold_buf_d    = hold_buf_q;
    redirect_pc_d = redirect_pc_q;

    case (state_q)
      S_RESET: state_d = S_FETCH;

      S_FETCH: begin
        if (imem.imem_ack) begin
          if (flush) begin
            id_valid_d = 1'b0;
            pc_d       = next_pc;
          end else if (!stall) begin
            id_instr_d    = imem.imem_rdata;
            id_pc_plus4_d = pc_plus4;
            id_valid_d    = 1'b1;
            pc_d          = next_pc;
          end else begin
            hold_buf_d = imem.imem_rdata;
            state_d    = S_HELD;
          end
        end else if (flush) begin
          // The outstanding request cannot be withdrawn, so remember where to go once it completes.
          redirect_pc_d = next_pc;
          id_valid_d    = 1'b0;
          state_d       = S_DISCARD;
        end else if (!stall) begin
          id_valid_d = 1'b0;
        end
      end

      S_HELD: begin
        if (flush) begin
          id_valid_d = 1'b0;
          pc_d       = next_pc;
          state_d    = S_FETCH;
        end else if (!stall) begin
          id_instr_d    = hold_buf_q;
          id_pc_plus4_d = pc_plus4;
          id_valid_d    = 1'b1;
          pc_d          = next_pc;
          state_d       = S_FETCH;
        end
      end

      S_DISCARD: begin
        if (flush) begin
          redirect_pc_d = next_pc;
        end
        if (flush || !stall) begin
          id_valid_d = 1'b0;
        end
        // A flush arriving with the ack wins over the older redirect target.
        if (imem.imem_ack) begin
          pc_d    = flush ? next_pc : redirect_pc_q;
          state_d = S_FETCH;
        end
      end

      default: state_d = S_RESET;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_RESET;
      pc_q          <= RESET_PC;
      id_instr_q    <= 32'd0;
      id_pc_plus4_q <= 32'd0;
      id_valid_q    <= 1'b0;
      hold_buf_q    <= 32'd0;
      redirect_pc_q <= 32'd0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      id_instr_q    <= id_instr_d;
      id_pc_plus4_q <= id_pc_plus4_d;
      id_valid_q    <= id_valid_d;
      hold_buf_q    <= hold_buf_d;
      redirect_pc_q <= redirect_pc_d;
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: a cycle-by-cycle vector table plus hand sequences
// for reset release timing and asynchronous reset while a fetch is held.
module tb_if_stage;

  logic        clk;
  logic        rst;
  logic [31:0] next_pc;
  logic [31:0] branch_imm;
  logic        stall;
  logic        flush;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [31:0] branch_target;
  logic [31:0] id_instr;
  logic [31:0] id_pc_plus4;
  logic        id_valid;

  if_stage_if imem ();

  if_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clk           (clk),
    .rst           (rst),
    .imem          (imem.master),
    .next_pc       (next_pc),
    .branch_imm    (branch_imm),
    .stall         (stall),
    .flush         (flush),
    .pc            (pc),
    .pc_plus4      (pc_plus4),
    .branch_target (branch_target),
    .id_instr      (id_instr),
    .id_pc_plus4   (id_pc_plus4),
    .id_valid      (id_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        stall;
    logic        flush;
    logic        ack;
    logic [31:0] rdata;
    logic [31:0] npc;
    logic [31:0] imm;
    logic        e_req;
    logic [31:0] e_pc;
    logic        e_idv;
    logic [31:0] e_instr;
    logic [31:0] e_idp4;
    logic [31:0] e_pp4;
    logic [31:0] e_bt;
  } vec_t;

  localparam int NV = 22;
  vec_t vecs [NV];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic drive_idle();
    stall = 1'b0; flush = 1'b0; next_pc = 32'd0; branch_imm = 32'd0;
    imem.imem_ack = 1'b0; imem.imem_rdata = 32'd0;
  endtask

  initial begin
    // stall flush ack rdata npc imm | req pc idv instr idp4 pp4 bt
    vecs[0]  = '{0,0,0,32'h0,        32'h0,        32'h0,        1, 32'h0,        0, 32'h0,        32'h0,        32'h4,        32'h0};
    vecs[1]  = '{0,0,1,32'h2001_0005,32'h4,        32'h0,        1, 32'h4,        1, 32'h2001_0005,32'h4,        32'h8,        32'h4};
    vecs[2]  = '{0,0,1,32'h1111_1111,32'h8,        32'h0,        1, 32'h8,        1, 32'h1111_1111,32'h8,        32'hC,        32'h8};
    vecs[3]  = '{0,0,1,32'h2222_2222,32'hC,        32'h0,        1, 32'hC,        1, 32'h2222_2222,32'hC,        32'h10,       32'hC};
    vecs[4]  = '{1,0,1,32'hAAAA_0000,32'h10,       32'h0,        0, 32'hC,        1, 32'h2222_2222,32'hC,        32'h10,       32'hC};
    vecs[5]  = '{1,0,0,32'h0,        32'h10,       32'h0,        0, 32'hC,        1, 32'h2222_2222,32'hC,        32'h10,       32'hC};
    vecs[6]  = '{0,0,0,32'h0,        32'h10,       32'h0,        1, 32'h10,       1, 32'hAAAA_0000,32'h10,       32'h14,       32'h10};
    vecs[7]  = '{0,1,0,32'h0,        32'h40,       32'h0,        1, 32'h10,       0, 32'hAAAA_0000,32'h10,       32'h14,       32'h10};
    vecs[8]  = '{0,0,0,32'h0,        32'h99,       32'h0,        1, 32'h10,       0, 32'hAAAA_0000,32'h10,       32'h14,       32'h10};
    vecs[9]  = '{0,0,1,32'hDEAD_BEEF,32'h77,       32'h0,        1, 32'h40,       0, 32'hAAAA_0000,32'h10,       32'h44,       32'h10};
    vecs[10] = '{0,0,1,32'h3333_3333,32'h44,       32'h0,        1, 32'h44,       1, 32'h3333_3333,32'h44,       32'h48,       32'h44};
    vecs[11] = '{1,0,0,32'h0,        32'h48,       32'h0,        1, 32'h44,       1, 32'h3333_3333,32'h44,       32'h48,       32'h44};
    vecs[12] = '{0,1,1,32'h5555_5555,32'h100,      32'h0,        1, 32'h100,      0, 32'h3333_3333,32'h44,       32'h104,      32'h44};
    vecs[13] = '{1,0,1,32'h6666_6666,32'h104,      32'h0,        0, 32'h100,      0, 32'h3333_3333,32'h44,       32'h104,      32'h44};
    vecs[14] = '{1,1,0,32'h0,        32'h200,      32'h0,        1, 32'h200,      0, 32'h3333_3333,32'h44,       32'h204,      32'h44};
    vecs[15] = '{0,1,0,32'h0,        32'h300,      32'h0,        1, 32'h200,      0, 32'h3333_3333,32'h44,       32'h204,      32'h44};
    vecs[16] = '{0,1,0,32'h0,        32'h400,      32'h0,        1, 32'h200,      0, 32'h3333_3333,32'h44,       32'h204,      32'h44};
    vecs[17] = '{0,0,1,32'h7777_7777,32'h500,      32'h0,        1, 32'h400,      0, 32'h3333_3333,32'h44,       32'h404,      32'h44};
    vecs[18] = '{0,0,1,32'h8888_8888,32'hFC,       32'h0,        1, 32'hFC,       1, 32'h8888_8888,32'h404,      32'h100,      32'h404};
    vecs[19] = '{0,0,1,32'h9999_9999,32'hFFFF_FFF8,32'hFFFF_FFFE,1, 32'hFFFF_FFF8,1, 32'h9999_9999,32'h100,      32'hFFFF_FFFC,32'hF8};
    vecs[20] = '{0,0,1,32'hBBBB_BBBB,32'h20,       32'h1,        1, 32'h20,       1, 32'hBBBB_BBBB,32'hFFFF_FFFC,32'h24,       32'h0};
    vecs[21] = '{0,0,1,32'hCCCC_CCCC,32'hFFFF_FFFC,32'h0,        1, 32'hFFFF_FFFC,1, 32'hCCCC_CCCC,32'h24,       32'h0,        32'h24};

    rst = 1'b1;
    drive_idle();
    #3;
    chk("reset_pc",       pc,                   32'h0);
    chk("reset_req",      {31'd0, imem.imem_req}, 32'd0);
    chk("reset_id_valid", {31'd0, id_valid},    32'd0);
    chk("reset_id_instr", id_instr,             32'h0);
    chk("reset_id_pc4",   id_pc_plus4,          32'h0);

    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_release_req_low", {31'd0, imem.imem_req}, 32'd0);

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      stall         = vecs[i].stall;
      flush         = vecs[i].flush;
      imem.imem_ack = vecs[i].ack;
      imem.imem_rdata = vecs[i].rdata;
      next_pc       = vecs[i].npc;
      branch_imm    = vecs[i].imm;
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_req", i),      {31'd0, imem.imem_req}, {31'd0, vecs[i].e_req});
      chk($sformatf("v%0d_pc", i),       pc,                     vecs[i].e_pc);
      chk($sformatf("v%0d_addr", i),     imem.imem_addr,         vecs[i].e_pc);
      chk($sformatf("v%0d_id_valid", i), {31'd0, id_valid},      {31'd0, vecs[i].e_idv});
      chk($sformatf("v%0d_id_instr", i), id_instr,               vecs[i].e_instr);
      chk($sformatf("v%0d_id_pc4", i),   id_pc_plus4,            vecs[i].e_idp4);
      chk($sformatf("v%0d_pc_plus4", i), pc_plus4,               vecs[i].e_pp4);
      chk($sformatf("v%0d_btarget", i),  branch_target,          vecs[i].e_bt);
    end

    // Enter S_HELD, then assert reset between edges.
    @(negedge clk);
    stall = 1'b1; flush = 1'b0; imem.imem_ack = 1'b1; imem.imem_rdata = 32'hEEEE_EEEE;
    next_pc = 32'h1234;
    @(posedge clk);
    #1;
    chk("held_req_low", {31'd0, imem.imem_req}, 32'd0);
    chk("held_pc",      pc,                     32'hFFFF_FFFC);
    imem.imem_ack = 1'b0;
    #1;
    rst = 1'b1;
    #1;
    chk("async_rst_req",      {31'd0, imem.imem_req}, 32'd0);
    chk("async_rst_pc",       pc,                     32'h0);
    chk("async_rst_id_valid", {31'd0, id_valid},      32'd0);
    chk("async_rst_id_instr", id_instr,               32'h0);

    // Release and confirm the request only appears after the first edge.
    @(negedge clk);
    drive_idle();
    rst = 1'b0;
    #1;
    chk("rerelease_req_low", {31'd0, imem.imem_req}, 32'd0);
    @(posedge clk);
    #1;
    chk("rerelease_req_high", {31'd0, imem.imem_req}, 32'd1);
    chk("rerelease_addr",     imem.imem_addr,         32'h0);
    @(posedge clk);
    #1;
    chk("idle_bubble_valid", {31'd0, id_valid}, 32'd0);
    chk("idle_pc_hold",      pc,                32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
